// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
//  serializer_pkg : shared types and helpers for the PISO transmit stage
//  Revision 1.0
// ============================================================================
package serializer_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } ser_state_t;

   // Counter width that never collapses to zero bits for tiny ranges.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = $clog2(value);
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_shreg.sv
`default_nettype none
// ============================================================================
//  shift_register : loadable, clearable bidirectional shift register
//  Revision 1.0
// ============================================================================
module shift_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             cl_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             shift_left_i,
   input  logic             shift_right_i,
   input  logic             input_bit_i,
   output logic [WIDTH-1:0] q_o,
   output logic             output_bit_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Clear beats load, load beats shift; left wins if both shifts are asked.
   always_comb begin
      data_d       = data_q;
      output_bit_o = 1'b0;
      if (load_i) begin
         data_d = data_i;
      end else if (shift_left_i) begin
         data_d       = {data_q[WIDTH-2:0], input_bit_i};
         output_bit_o = data_q[WIDTH-1];
      end else if (shift_right_i) begin
         data_d       = {input_bit_i, data_q[WIDTH-1:1]};
         output_bit_o = data_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (cl_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  piso_serializer : valid/ready word in, one bit per BIT_PERIOD clocks out
//  Revision 1.0
// ============================================================================
module piso_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BIT_PERIOD = 1,
   parameter int MSB_FIRST  = 1,
   parameter int IDLE_LEVEL = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic                  sout,
   output logic                  sout_valid,
   output logic                  bit_strobe,
   output logic                  busy,
   output logic                  done
);

   localparam int BCW = $clog2(DATA_WIDTH);
   localparam int PCW = clog2_min1(BIT_PERIOD);

   localparam logic [PCW-1:0] PRESC_LAST = PCW'(BIT_PERIOD - 1);
   localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_WIDTH - 1);
   localparam logic           IDLE_BIT   = (IDLE_LEVEL != 0);
   localparam logic           MSB_SEL    = (MSB_FIRST != 0);

   ser_state_t           state_q,   state_d;
   logic [PCW-1:0]       presc_q,   presc_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 done_q,    done_d;
   logic                 strobe_q,  strobe_d;

   logic                  handshake;
   logic                  in_shift;
   logic                  presc_wrap;
   logic                  last_bit;
   logic                  shift_en;
   logic                  tx_bit;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  sr_out_bit;
   logic                  unused_sr;

   assign in_shift   = (state_q == S_SHIFT);
   assign din_ready  = (state_q == S_IDLE) & ~rst;
   assign handshake  = din_valid & din_ready;
   assign presc_wrap = (presc_q == PRESC_LAST);
   assign last_bit   = (bit_cnt_q == BIT_LAST);
   assign shift_en   = in_shift & presc_wrap;

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      strobe_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (handshake) begin
               state_d   = S_SHIFT;
               presc_d   = '0;
               bit_cnt_d = '0;
               strobe_d  = 1'b1;
            end
         end
         S_SHIFT: begin
            if (presc_wrap) begin
               presc_d   = '0;
               bit_cnt_d = bit_cnt_q + BCW'(1);
               // The strobe marks the start of the next bit, so none after the last.
               if (last_bit) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  strobe_d = 1'b1;
               end
            end else begin
               presc_d = presc_q + PCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         strobe_q  <= strobe_d;
      end
   end

   shift_register #(
      .WIDTH (DATA_WIDTH)
   ) u_shreg (
      .clk           (clk),
      .cl_i          (rst),
      .load_i        (handshake),
      .data_i        (din),
      .shift_left_i  (shift_en & MSB_SEL),
      .shift_right_i (shift_en & ~MSB_SEL),
      .input_bit_i   (IDLE_BIT),
      .q_o           (shreg),
      .output_bit_o  (sr_out_bit)
   );

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign tx_bit = shreg[DATA_WIDTH-1];
      end else begin : g_lsb_first
         assign tx_bit = shreg[0];
      end
   endgenerate

   // Only the head bit of the register is observable on the line.
   assign unused_sr = &{1'b0, shreg, sr_out_bit};

   assign busy       = in_shift;
   assign sout_valid = in_shift & ~rst;
   assign sout       = (in_shift & ~rst) ? tx_bit : IDLE_BIT;
   assign bit_strobe = strobe_q;
   assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  tb_piso_serializer : four serializer configurations against a timing model
//  Revision 1.0
// ============================================================================
module tb_piso_serializer;

   localparam int WA [4] = '{8, 8, 5, 5};
   localparam int PA [4] = '{1, 3, 2, 2};
   localparam int MA [4] = '{1, 0, 1, 0};
   localparam int IA [4] = '{1, 1, 1, 0};

   logic       clk = 1'b0;
   logic       rst_v   [4];
   logic [7:0] din_v   [4];
   logic       val_v   [4];
   logic       rdy_v   [4];
   logic       sout_v  [4];
   logic       sv_v    [4];
   logic       bs_v    [4];
   logic       busy_v  [4];
   logic       done_v  [4];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state: word age in cycles since handshake
   bit         m_busy     [4];
   int         m_t        [4];
   logic [7:0] m_word     [4];
   bit         m_done     [4];
   int         m_done_cnt [4];

   int         dut_hs_cnt   [4];
   int         dut_hs_time  [4];
   int         dut_done_cnt [4];
   logic [7:0] asm_v        [4];

   always #5 clk = ~clk;

   piso_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(1), .MSB_FIRST(1), .IDLE_LEVEL(1)) u_a (
      .clk(clk), .rst(rst_v[0]), .din(din_v[0]), .din_valid(val_v[0]), .din_ready(rdy_v[0]),
      .sout(sout_v[0]), .sout_valid(sv_v[0]), .bit_strobe(bs_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   piso_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(3), .MSB_FIRST(0), .IDLE_LEVEL(1)) u_b (
      .clk(clk), .rst(rst_v[1]), .din(din_v[1]), .din_valid(val_v[1]), .din_ready(rdy_v[1]),
      .sout(sout_v[1]), .sout_valid(sv_v[1]), .bit_strobe(bs_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   piso_serializer #(.DATA_WIDTH(5), .BIT_PERIOD(2), .MSB_FIRST(1), .IDLE_LEVEL(1)) u_c (
      .clk(clk), .rst(rst_v[2]), .din(din_v[2][4:0]), .din_valid(val_v[2]), .din_ready(rdy_v[2]),
      .sout(sout_v[2]), .sout_valid(sv_v[2]), .bit_strobe(bs_v[2]), .busy(busy_v[2]), .done(done_v[2]));
   piso_serializer #(.DATA_WIDTH(5), .BIT_PERIOD(2), .MSB_FIRST(0), .IDLE_LEVEL(0)) u_d (
      .clk(clk), .rst(rst_v[3]), .din(din_v[3][4:0]), .din_valid(val_v[3]), .din_ready(rdy_v[3]),
      .sout(sout_v[3]), .sout_valid(sv_v[3]), .bit_strobe(bs_v[3]), .busy(busy_v[3]), .done(done_v[3]));

   function automatic void chk(input string nm, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, idx, cyc, act, exp);
      end
   endfunction

   function automatic logic [7:0] wmask(input int w);
      return 8'((1 << w) - 1);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle compare against the timing model, then advance the model.
   always @(negedge clk) begin : p_cmp
      int   k;
      int   bidx;
      logic e_bit;
      logic e_strobe;
      logic e_sout;
      for (int i = 0; i < 4; i++) begin
         e_bit    = 1'b0;
         e_strobe = 1'b0;
         if (m_busy[i]) begin
            k        = (m_t[i] - 1) / PA[i];
            bidx     = (MA[i] != 0) ? (WA[i] - 1 - k) : k;
            e_bit    = m_word[i][bidx];
            e_strobe = (((m_t[i] - 1) % PA[i]) == 0);
         end
         e_sout = (m_busy[i] && !rst_v[i]) ? e_bit : (IA[i] != 0);
         if (cyc >= 1) begin
            chk("sout",       i, sout_v[i], e_sout);
            chk("din_ready",  i, rdy_v[i],  !m_busy[i] && !rst_v[i]);
            chk("sout_valid", i, sv_v[i],   m_busy[i] && !rst_v[i]);
            chk("busy",       i, busy_v[i], m_busy[i]);
            chk("done",       i, done_v[i], m_done[i]);
            chk("bit_strobe", i, bs_v[i],   e_strobe);
            if (bs_v[i] === 1'b1) begin
               if (MA[i] != 0)
                  asm_v[i] <= ((asm_v[i] << 1) | 8'(sout_v[i])) & wmask(WA[i]);
               else
                  asm_v[i] <= (asm_v[i] >> 1) | (8'(sout_v[i]) << (WA[i] - 1));
            end
            if (done_v[i] === 1'b1) begin
               dut_done_cnt[i] <= dut_done_cnt[i] + 1;
               chk("word", i, asm_v[i], m_word[i]);
            end
         end
         if (val_v[i] === 1'b1 && rdy_v[i] === 1'b1) begin
            dut_hs_cnt[i]  <= dut_hs_cnt[i] + 1;
            dut_hs_time[i] <= cyc + 1;
         end
         if (rst_v[i]) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
         end else if (m_busy[i]) begin
            if (m_t[i] == WA[i] * PA[i]) begin
               m_busy[i]     <= 1'b0;
               m_done[i]     <= 1'b1;
               m_done_cnt[i] <= m_done_cnt[i] + 1;
            end else begin
               m_t[i]    <= m_t[i] + 1;
               m_done[i] <= 1'b0;
            end
         end else begin
            m_done[i] <= 1'b0;
            if (val_v[i]) begin
               m_busy[i] <= 1'b1;
               m_t[i]    <= 1;
               m_word[i] <= din_v[i] & wmask(WA[i]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input int i, input logic [7:0] w);
      din_v[i] = w;
      val_v[i] = 1'b1;
      step();
      val_v[i] = 1'b0;
   endtask

   task automatic drive_rand(input int i);
      int gap;
      int base;
      int waited;
      for (int n = 0; n < 200; n++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) step();
         base     = dut_hs_cnt[i];
         waited   = 0;
         din_v[i] = 8'($urandom);
         val_v[i] = 1'b1;
         while (dut_hs_cnt[i] == base && waited < 60) begin
            step();
            waited++;
         end
         val_v[i] = 1'b0;
         if (waited >= 60) begin
            total++;
            bad++;
            $display("FAIL hs_timeout dut%0d: got no handshake, required one within 60 cycles", i);
         end
      end
   endtask

   initial begin
      logic [7:0] pat;
      int         t1;
      int         base;
      int         dcnt;
      for (int i = 0; i < 4; i++) begin
         rst_v[i] = 1'b1; din_v[i] = 8'h00; val_v[i] = 1'b0;
         m_busy[i] = 1'b0; m_t[i] = 0; m_word[i] = 8'h00; m_done[i] = 1'b0;
         m_done_cnt[i] = 0; dut_hs_cnt[i] = 0; dut_hs_time[i] = 0;
         dut_done_cnt[i] = 0; asm_v[i] = 8'h00;
      end
      t1 = 0;

      // reset held with a pending word
      val_v[0] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("rst_ready", 0, rdy_v[0], 1'b0);
         chk("rst_sout",  0, sout_v[0], 1'b1);
         chk("rst_busy",  0, busy_v[0], 1'b0);
      end
      for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;
      val_v[0] = 1'b0;
      #1;
      chk("rel_ready", 0, rdy_v[0], 1'b1);
      step();

      // A5 MSB first, one clock per bit
      pat = 8'hA5;
      send_one(0, pat);
      for (int k = 0; k < 8; k++) begin
         chk("t2_sout", 0, sout_v[0], pat[7-k]);
         chk("t2_done", 0, done_v[0], 1'b0);
         step();
      end
      chk("t2_done_hi", 0, done_v[0], 1'b1);
      chk("t2_idle",    0, sout_v[0], 1'b1);
      step();
      chk("t2_done_lo", 0, done_v[0], 1'b0);

      // 01 LSB first, three clocks per bit
      send_one(1, 8'h01);
      for (int c = 1; c <= 24; c++) begin
         chk("t3_sout",   1, sout_v[1], (c <= 3));
         chk("t3_strobe", 1, bs_v[1],   ((c - 1) % 3 == 0));
         chk("t3_done",   1, done_v[1], 1'b0);
         step();
      end
      chk("t3_done_hi", 1, done_v[1], 1'b1);
      step();

      // valid held across two words
      base     = dut_hs_cnt[0];
      din_v[0] = 8'hF0;
      val_v[0] = 1'b1;
      for (int n = 0; n < 40; n++) begin
         step();
         if (dut_hs_cnt[0] == base + 1 && din_v[0] != 8'h0F) begin
            t1       = dut_hs_time[0];
            din_v[0] = 8'h0F;
         end
         if (dut_hs_cnt[0] >= base + 2) break;
      end
      val_v[0] = 1'b0;
      chk("t4_gap", 0, dut_hs_time[0] - t1, 9);
      dcnt = dut_done_cnt[0];
      repeat (12) step();
      chk("t4_hs_count", 0, dut_hs_cnt[0] - base, 2);
      chk("t4_dones",    0, dut_done_cnt[0] - dcnt, 1);

      // reset in the middle of a word
      dcnt = dut_done_cnt[0];
      send_one(0, 8'hFF);
      repeat (3) step();
      rst_v[0] = 1'b1;
      #1;
      chk("t5_sout_rst", 0, sout_v[0], 1'b1);
      step();
      rst_v[0] = 1'b0;
      #1;
      chk("t5_ready", 0, rdy_v[0], 1'b1);
      repeat (10) step();
      chk("t5_nodone", 0, dut_done_cnt[0] - dcnt, 0);
      send_one(0, 8'h3C);
      repeat (10) step();
      chk("t5_done_after", 0, dut_done_cnt[0] - dcnt, 1);
      chk("t5_word", 0, asm_v[0], 8'h3C);

      // randomised traffic on both bit orders
      fork
         drive_rand(2);
         drive_rand(3);
      join
      repeat (20) step();
      for (int i = 2; i < 4; i++) begin
         chk("rand_hs",    i, dut_hs_cnt[i],   200);
         chk("rand_dones", i, dut_done_cnt[i], m_done_cnt[i]);
         chk("rand_all",   i, m_done_cnt[i],   200);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
